// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - four-digit time-multiplexed 7-segment scanner front end
// Prescaled slot timing, dead time, frame-synchronous update, leading-zero blanking, invalid-code flag.
module seg_scan_mux #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  bcd_out,
  output logic        dp_out,
  output logic        blank_out,
  output logic [3:0]  dig_sel,
  output logic        frame_done,
  output logic        err_out
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  generate
    if (BLANK >= DIV) begin : g_bad_params
      $error("seg_scan_mux: BLANK must be smaller than DIV");
    end
  endgenerate

  logic [PW-1:0] presc, presc_nx;
  logic [1:0]    idx, idx_nx;
  logic [15:0]   pend_dig, disp_dig, disp_dig_nx;
  logic [3:0]    pend_dp, disp_dp, disp_dp_nx;
  logic          pend_flag;
  logic          adv, wrap;
  logic [3:0]    digit;
  logic          higher_zero, bad_code, in_dead;

  always_comb begin
    adv         = en && (presc == LAST);
    wrap        = adv && (idx == 2'd3);
    presc_nx    = presc;
    idx_nx      = idx;
    disp_dig_nx = disp_dig;
    disp_dp_nx  = disp_dp;
    if (en) begin
      if (adv) begin
        presc_nx = '0;
        idx_nx   = idx + 2'd1;
      end else begin
        presc_nx = presc + PW'(1);
      end
    end
    // A load coinciding with the wrap bypasses the pending register.
    if (wrap) begin
      if (load) begin
        disp_dig_nx = digits_in;
        disp_dp_nx  = dp_in;
      end else if (pend_flag) begin
        disp_dig_nx = pend_dig;
        disp_dp_nx  = pend_dp;
      end
    end
  end

  always_comb begin
    digit       = disp_dig_nx[3:0];
    higher_zero = 1'b0;
    case (idx_nx)
      2'd0: begin digit = disp_dig_nx[3:0];   higher_zero = 1'b0;                    end
      2'd1: begin digit = disp_dig_nx[7:4];   higher_zero = disp_dig_nx[15:4] == '0;  end
      2'd2: begin digit = disp_dig_nx[11:8];  higher_zero = disp_dig_nx[15:8] == '0;  end
      2'd3: begin digit = disp_dig_nx[15:12]; higher_zero = disp_dig_nx[15:12] == '0; end
      default: ;
    endcase
    bad_code = digit > 4'd9;
  end

  generate
    if (BLANK == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = presc_nx < PW'(BLANK);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      disp_dig   <= '0;
      disp_dp    <= '0;
      bcd_out    <= '0;
      dp_out     <= 1'b0;
      blank_out  <= 1'b1;
      dig_sel    <= '0;
      frame_done <= 1'b0;
      err_out    <= 1'b0;
    end else begin
      presc      <= presc_nx;
      idx        <= idx_nx;
      disp_dig   <= disp_dig_nx;
      disp_dp    <= disp_dp_nx;
      frame_done <= wrap;
      if (wrap) begin
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_dig  <= digits_in;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end
      dig_sel <= (en && !in_dead) ? (4'b0001 << idx_nx) : 4'b0000;
      // Slot data is latched once at slot start so it is stable for the whole slot.
      if (adv) begin
        bcd_out   <= digit;
        dp_out    <= disp_dp_nx[idx_nx];
        blank_out <= bad_code || (lz_en && higher_zero);
        if (bad_code) begin
          err_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Four-digit time-multiplexed scanner that drives the shared BCD-to-7-segment decoder stage.
- Each scan slot presents one BCD nibble, its decimal point and a blank flag to the decoder inputs (bcd_out[3] = MSB), and enables one digit's common line.
- Includes a prescaler, anti-ghosting dead time, frame-synchronous value update, leading-zero suppression and invalid-code detection.

Parameters:
DIV, 50000, clock cycles per digit slot; legal range 2..2^20.
BLANK, 16, dead-time cycles at the start of each slot with all digits off; legal range 0..DIV-1.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
en  input  1  scan enable
load  input  1  one-cycle strobe; captures digits_in/dp_in
digits_in  input  16  four BCD digits; [15:12] = digit 3 (leftmost), [3:0] = digit 0
dp_in  input  4  per-digit decimal point; bit k belongs to digit k
lz_en  input  1  leading-zero suppression enable
bcd_out  output  4  nibble to the decoder; bit 3 = MSB
dp_out  output  1  decimal point for the current digit
blank_out  output  1  decoder must drive all segments off
dig_sel  output  4  one-hot, active-high digit enable
frame_done  output  1  one-cycle pulse on the 3->0 index wrap
err_out  output  1  sticky flag: a displayed digit was > 9

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is synchronous and active-low. All outputs are registered.
- Reset values (rst_n sampled low):
  - Prescaler = 0, index = 0.
  - Pending and display registers = 0.
  - bcd_out = 0, dp_out = 0, blank_out = 1, dig_sel = 0, frame_done = 0, err_out = 0.
  - Reset asserted mid-slot or mid-frame aborts the slot immediately. Any pending load is discarded.
- Pending register: load = 1 captures digits_in/dp_in into the pending register and sets a pending flag. A later load before the wrap overwrites the pending value (last load wins).
- Prescaler and slot timing (en = 1):
  - Prescaler counts 0..DIV-1.
  - When it reaches DIV-1, it returns to 0 and the index advances: 0->1->2->3->0.
- Display register update:
  - The display register is updated only on the 3->0 wrap, and only if the pending flag is set; the flag is then cleared.
  - If load coincides with the wrap cycle, the data on the load inputs goes straight into the display register and no pending flag remains.
- Slot outputs:
  - bcd_out, dp_out and blank_out for slot k are valid from the first cycle of slot k and stay constant for the whole slot.
  - dig_sel = 0 while prescaler < BLANK. dig_sel = (1 << k) while prescaler >= BLANK.
  - With BLANK = 0, dig_sel is never zero while enabled.
- Blanking rules:
  - blank_out = 1 when the digit value is > 9; err_out is then set and held until reset.
  - blank_out = 1 when lz_en = 1 and the digit is a leading zero: digit k (k = 3,2,1) is zero and every higher digit is zero.
  - Digit 0 is never suppressed.
  - dp_out follows dp_in[k] from the display register even when the digit is blanked.
- frame_done: pulses for exactly 1 cycle, coincident with the first cycle of slot 0.
- en = 0:
  - Prescaler and index hold; dig_sel = 0 on the next cycle; the other outputs hold.
  - load is still accepted into the pending register.
  - When en is re-asserted, scanning resumes from the held count, and the dead-time rule is re-evaluated against that count.
- Parameter rule: BLANK >= DIV is illegal; the design must check this at elaboration time.

Test Plan (DIV = 8, BLANK = 2 unless stated):
1. Release reset, en = 1, load digits_in = 16'h1234, dp_in = 4'b0100:
   - After the first wrap, slots show 4, 3, 2, 1 on bcd_out with dig_sel 0001, 0010, 0100, 1000.
   - dig_sel is 0 for the first 2 cycles of each slot; dp_out = 1 only in slot 2.
   - frame_done pulses once every 32 cycles.
2. lz_en = 1, load 16'h0050:
   - Digits 3 and 2 have blank_out = 1.
   - Digit 1 (value 5) and digit 0 (value 0) are displayed.
   - load 16'h0000 blanks digits 3..1; digit 0 shows 0.
3. load 16'h00A1:
   - Slot 1 shows blank_out = 1, and err_out rises in that slot.
   - err_out stays 1 after load 16'h1111; only rst_n = 0 clears it.
4. Mid-frame (slot 1) load 16'h5555, then load 16'h6666 in slot 2:
   - Slots 2 and 3 still show the old value.
   - From the next slot 0 all digits show 6.
   - Load asserted exactly in the wrap cycle takes effect in that same frame.
5. Drop en for 5 cycles in slot 2 at prescaler = 4:
   - dig_sel = 0 during the gap; index and prescaler hold.
   - After re-enable, slot 2 finishes its remaining 4 cycles.
   - Pulse rst_n low for 1 cycle mid-slot: all outputs return to reset values the following cycle and the pending load is lost.
6. BLANK = 0, DIV = 2:
   - dig_sel rotates every 2 cycles with no zero gap.
   - frame_done pulses every 8 cycles.
